// File: rtl/lu_op_sequencer_if.sv
// lu_op_sequencer_if: command and result handshakes between a host and the LU sequencer.
interface lu_op_sequencer_if #(parameter int WIDTH = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_sel;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_y;
    logic [1:0]       res_sel;
    logic             res_zero;
    logic             res_parity;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
        input  cmd_ready, res_valid, res_y, res_sel, res_zero, res_parity
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
        output cmd_ready, res_valid, res_y, res_sel, res_zero, res_parity
    );
endinterface

// File: rtl/lu_op_sequencer.sv
// lu_op_sequencer: launches one op into the 4-bit LU, holds operands while it settles, returns flagged result.
module lu_op_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    lu_op_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]   lu_a,
    output logic [WIDTH-1:0]   lu_b,
    output logic [1:0]         lu_s,
    input  logic [WIDTH-1:0]   lu_y,
    output logic [CNT_W-1:0]   op_count
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    // cmd_ready is registered, so a consume edge is always followed by one IDLE bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            lu_a           <= '0;
            lu_b           <= '0;
            lu_s           <= '0;
            op_count       <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_y      <= '0;
            bus.res_sel    <= '0;
            bus.res_zero   <= 1'b0;
            bus.res_parity <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_ready && bus.cmd_valid) begin
                        lu_a          <= bus.cmd_a;
                        lu_b          <= bus.cmd_b;
                        lu_s          <= bus.cmd_sel;
                        cnt           <= CW'(SETTLE_CYCLES);
                        bus.cmd_ready <= 1'b0;
                        state         <= SETTLE;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CW'(1)) begin
                        bus.res_y      <= lu_y;
                        bus.res_sel    <= lu_s;
                        bus.res_zero   <= ~|lu_y;
                        bus.res_parity <= ^lu_y;
                        bus.res_valid  <= 1'b1;
                        state          <= RESULT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lu_op_sequencer.sv
// tb_lu_op_sequencer: directed vectors for the LU sequencer, default instance plus a SETTLE_CYCLES=3 instance.
module tb_lu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] lu_a1, lu_b1, lu_y1, lu_a2, lu_b2, lu_y2;
    logic [1:0] lu_s1, lu_s2;
    logic [7:0] op_count1, op_count2;
    logic [7:0] exp_cnt;
    int         compared = 0;
    int         mismatched = 0;

    lu_op_sequencer_if #(.WIDTH(4)) bus1 ();
    lu_op_sequencer_if #(.WIDTH(4)) bus2 ();

    lu_op_sequencer dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .lu_a(lu_a1), .lu_b(lu_b1),
                          .lu_s(lu_s1), .lu_y(lu_y1), .op_count(op_count1));
    lu_op_sequencer #(.SETTLE_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .lu_a(lu_a2),
                          .lu_b(lu_b2), .lu_s(lu_s2), .lu_y(lu_y2), .op_count(op_count2));

    always #5 clk = ~clk;

    function automatic logic [3:0] lu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        return s == 2'd0 ? (a & b) : s == 2'd1 ? (a | b) : s == 2'd2 ? (a ^ b) : ~a;
    endfunction

    assign lu_y1 = lu_f(lu_a1, lu_b1, lu_s1);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] y;
        logic       zero;
        logic       parity;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus1.cmd_ready && n < 10) begin
            tick();
            n++;
        end
        chk("cmd_ready_timeout", 32'(bus1.cmd_ready), 32'd1);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                         input logic [3:0] y, input logic zero, input logic parity);
        wait_ready();
        bus1.cmd_a = a;
        bus1.cmd_b = b;
        bus1.cmd_sel = sel;
        bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_valid = 1'b0;
        chk("lu_launch", 32'({lu_a1, lu_b1, lu_s1}), 32'({a, b, sel}));
        chk("settle_flags", 32'({bus1.res_valid, bus1.cmd_ready}), 32'd0);
        tick();
        chk("res_valid", 32'(bus1.res_valid), 32'd1);
        chk("res_y", 32'(bus1.res_y), 32'(y));
        chk("res_sel", 32'(bus1.res_sel), 32'(sel));
        chk("res_flags", 32'({bus1.res_zero, bus1.res_parity}), 32'({zero, parity}));
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        exp_cnt++;
        chk("consume", 32'({bus1.res_valid, bus1.cmd_ready}), 32'd0);
        chk("op_count", 32'(op_count1), 32'(exp_cnt));
    endtask

    task automatic rand_op();
        logic [3:0] a, b, y;
        logic [1:0] s;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        s = 2'($urandom_range(0, 3));
        y = lu_f(a, b, s);
        do_op(a, b, s, y, ~|y, ^y);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_sel = '0; bus1.res_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_a = '0; bus2.cmd_b = '0; bus2.cmd_sel = '0; bus2.res_ready = 1'b0;
        lu_y2 = 4'h5;
        exp_cnt = '0;
        vt[0] = '{4'hC, 4'hA, 2'd0, 4'h8, 1'b0, 1'b1};
        vt[1] = '{4'hC, 4'hA, 2'd1, 4'hE, 1'b0, 1'b1};
        vt[2] = '{4'hC, 4'hA, 2'd2, 4'h6, 1'b0, 1'b0};
        vt[3] = '{4'hF, 4'hA, 2'd3, 4'h0, 1'b1, 1'b0};
        vt[4] = '{4'h3, 4'h5, 2'd0, 4'h1, 1'b0, 1'b1};
        vt[5] = '{4'h3, 4'h5, 2'd1, 4'h7, 1'b0, 1'b1};
        vt[6] = '{4'h3, 4'h5, 2'd2, 4'h6, 1'b0, 1'b0};
        vt[7] = '{4'h0, 4'h9, 2'd3, 4'hF, 1'b0, 1'b0};
        vt[8] = '{4'h0, 4'h0, 2'd0, 4'h0, 1'b1, 1'b0};

        // reset: everything low while rst_n is held, ready one edge after release
        repeat (3) begin
            tick();
            chk("reset_outputs", 32'({bus1.cmd_ready, bus1.res_valid, bus1.res_y, bus1.res_sel,
                bus1.res_zero, bus1.res_parity, lu_a1, lu_b1, lu_s1, op_count1}), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(bus1.cmd_ready), 32'd0);
        tick();
        chk("ready_after_edge", 32'(bus1.cmd_ready), 32'd1);
        chk("count_after_reset", 32'(op_count1), 32'd0);

        for (int i = 0; i < 9; i++) do_op(vt[i].a, vt[i].b, vt[i].sel, vt[i].y, vt[i].zero, vt[i].parity);

        // backpressure: result held, new command ignored until consume plus one cycle
        wait_ready();
        bus1.cmd_a = 4'hC; bus1.cmd_b = 4'hA; bus1.cmd_sel = 2'd0; bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_a = 4'h3; bus1.cmd_b = 4'h5; bus1.cmd_sel = 2'd1;
        tick();
        repeat (5) begin
            tick();
            chk("bp_res", 32'({bus1.res_valid, bus1.res_y, bus1.res_sel}), 32'({1'b1, 4'h8, 2'd0}));
            chk("bp_lu", 32'({lu_a1, lu_b1, lu_s1}), 32'({4'hC, 4'hA, 2'd0}));
            chk("bp_ready", 32'(bus1.cmd_ready), 32'd0);
        end
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        exp_cnt++;
        chk("bp_consume", 32'({bus1.res_valid, bus1.cmd_ready, lu_a1}), 32'({1'b0, 1'b0, 4'hC}));
        tick();
        chk("bp_bubble", 32'({bus1.cmd_ready, lu_a1}), 32'({1'b1, 4'hC}));
        tick();
        bus1.cmd_valid = 1'b0;
        chk("bp_accept", 32'({lu_a1, lu_b1, lu_s1}), 32'({4'h3, 4'h5, 2'd1}));
        tick();
        chk("bp_result", 32'({bus1.res_valid, bus1.res_y}), 32'({1'b1, 4'h7}));
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        exp_cnt++;
        chk("bp_count", 32'(op_count1), 32'(exp_cnt));

        // SETTLE_CYCLES=3: only the value present at the third edge is captured
        bus2.cmd_a = 4'h1; bus2.cmd_b = 4'h2; bus2.cmd_sel = 2'd2; bus2.cmd_valid = 1'b1;
        begin
            int n = 0;
            while (!bus2.cmd_ready && n < 10) begin tick(); n++; end
            chk("s3_ready_timeout", 32'(bus2.cmd_ready), 32'd1);
        end
        tick();
        bus2.cmd_valid = 1'b0;
        lu_y2 = 4'h9;
        chk("s3_t0", 32'({bus2.res_valid, lu_a2, lu_b2, lu_s2}), 32'({1'b0, 4'h1, 4'h2, 2'd2}));
        tick();
        lu_y2 = 4'hF;
        chk("s3_t1", 32'(bus2.res_valid), 32'd0);
        tick();
        lu_y2 = 4'h3;
        chk("s3_t2", 32'(bus2.res_valid), 32'd0);
        tick();
        chk("s3_t3", 32'({bus2.res_valid, bus2.res_y, bus2.res_sel, bus2.res_zero, bus2.res_parity}),
            32'({1'b1, 4'h3, 2'd2, 1'b0, 1'b0}));
        bus2.res_ready = 1'b1;
        tick();
        bus2.res_ready = 1'b0;
        chk("s3_count", 32'({bus2.res_valid, op_count2}), 32'({1'b0, 8'd1}));

        // reset mid-op in SETTLE then in RESULT abandons the op
        pulse_reset();
        wait_ready();
        bus1.cmd_a = 4'h6; bus1.cmd_b = 4'h3; bus1.cmd_sel = 2'd0; bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_settle", 32'({bus1.res_valid, bus1.cmd_ready, lu_a1, op_count1}), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready();
        bus1.cmd_valid = 1'b1;
        tick();
        bus1.cmd_valid = 1'b0;
        tick();
        chk("rst_result_pre", 32'(bus1.res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_result", 32'({bus1.res_valid, bus1.res_y, op_count1}), 32'd0);
        tick();
        rst_n = 1'b1;
        do_op(4'h6, 4'h3, 2'd1, 4'h7, 1'b0, 1'b1);

        // counter wrap from reset
        pulse_reset();
        for (int i = 0; i < 255; i++) rand_op();
        chk("wrap_255", 32'(op_count1), 32'd255);
        rand_op();
        chk("wrap_0", 32'(op_count1), 32'd0);
        rand_op();
        chk("wrap_1", 32'(op_count1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
